// File: rtl/lcd_write_sched.sv
// lcd_write_sched: round-robin owner of the shared HD44780 command port.
// Optional LCD_SCHED_ADDR_SKIP_EN drops the address command on contiguous writes.
module lcd_write_sched #(
  parameter int N_REQ       = 2,
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [8*N_REQ-1:0] req_char,
  input  logic [7*N_REQ-1:0] req_addr,
  input  logic [N_REQ-1:0]   req_last,
  output logic               lcd_valid,
  input  logic               lcd_ready,
  output logic               lcd_rs,
  output logic [7:0]         lcd_data,
  output logic [N_REQ-1:0]   grant,
  output logic               timeout_err
);
  localparam int PW = $clog2(N_REQ);
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] T_END = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, LOCK, ADDR, CHAR} state_t;

  state_t        state, nxt;
  logic [PW-1:0] rr_ptr, win, hi, lo;
  logic          hi_ok;
  logic [TW-1:0] timer;
  logic          tmo, skip_win, skip_own;
  logic [N_REQ-1:0] own_oh;
  logic [6:0]    own_addr;
  logic [7:0]    own_char;
  logic [6:0]    addr_a [N_REQ];
  logic [7:0]    char_a [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_sl
    assign addr_a[i] = req_addr[7*i +: 7];
    assign char_a[i] = req_char[8*i +: 8];
  end

  // rr_ptr doubles as the owner index while a grant is held
  assign own_oh   = N_REQ'(1) << rr_ptr;
  assign own_addr = addr_a[rr_ptr];
  assign own_char = char_a[rr_ptr];
  assign tmo      = (state == LOCK) && (timer == T_END);

  always_comb begin
    hi    = '0;
    lo    = '0;
    hi_ok = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) lo = PW'(i);
      if (req_valid[i] && (PW'(i) > rr_ptr)) begin
        hi_ok = 1'b1;
        hi    = PW'(i);
      end
    end
    win = hi_ok ? hi : lo;
  end

`ifdef LCD_SCHED_ADDR_SKIP_EN
  logic [6:0] cursor;
  logic       cursor_ok;

  assign skip_win = cursor_ok && (addr_a[win] == cursor);
  assign skip_own = cursor_ok && (own_addr == cursor);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cursor    <= '0;
      cursor_ok <= 1'b0;
    end else if (state == ADDR && lcd_ready) begin
      cursor    <= own_addr;
      cursor_ok <= 1'b1;
    end else if (state == CHAR && lcd_ready) begin
      cursor    <= cursor + 7'd1;
    end else if (tmo) begin
      cursor_ok <= 1'b0;
    end
  end
`else
  assign skip_win = 1'b0;
  assign skip_own = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      rr_ptr <= PW'(N_REQ - 1);
      timer  <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && |req_valid) rr_ptr <= win;
      if (state == LOCK && nxt == LOCK) timer <= timer + TW'(1);
      else timer <= '0;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (|req_valid) nxt = skip_win ? CHAR : ADDR;
      ADDR: if (lcd_ready) nxt = CHAR;
      CHAR: if (lcd_ready) nxt = req_last[rr_ptr] ? IDLE : LOCK;
      LOCK: begin
        // timeout wins over a beat arriving in the same cycle
        if (tmo) nxt = IDLE;
        else if (req_valid[rr_ptr]) nxt = skip_own ? CHAR : ADDR;
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    lcd_valid   = 1'b0;
    lcd_rs      = 1'b0;
    lcd_data    = '0;
    req_ready   = '0;
    grant       = '0;
    timeout_err = 1'b0;
    unique case (state)
      ADDR: begin
        lcd_valid = 1'b1;
        lcd_data  = {1'b1, own_addr};
        grant     = own_oh;
      end
      CHAR: begin
        lcd_valid = 1'b1;
        lcd_rs    = 1'b1;
        lcd_data  = own_char;
        grant     = own_oh;
        if (lcd_ready) req_ready = own_oh;
      end
      LOCK: begin
        grant       = own_oh;
        timeout_err = tmo;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_lcd_write_sched.sv
// tb_lcd_write_sched: directed and random stimulus against a
// transaction-level model of the LCD write scheduler.
`timescale 1ns/1ps
module tb_lcd_write_sched;
  localparam int N  = 2;
  localparam int TO = 16;

  typedef struct packed {
    logic [6:0] a;
    logic [7:0] c;
    logic       l;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [8*N-1:0] req_char = '0;
  logic [7*N-1:0] req_addr = '0;
  logic [N-1:0] req_last = '0;
  logic         lcd_valid;
  logic         lcd_ready = 1'b0;
  logic         lcd_rs;
  logic [7:0]   lcd_data;
  logic [N-1:0] grant;
  logic         timeout_err;

  always #5 clk = ~clk;

  lcd_write_sched #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_char(req_char), .req_addr(req_addr), .req_last(req_last),
    .lcd_valid(lcd_valid), .lcd_ready(lcd_ready),
    .lcd_rs(lcd_rs), .lcd_data(lcd_data),
    .grant(grant), .timeout_err(timeout_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // requester queues
  beat_t mem [N][256];
  int hd [N];
  int tl [N];
  int gap [N];
  int gmax = 0;

  // model state
  int owner, rr, lock_cnt, cyc;
  logic in_lock, phase, cok;
  logic [6:0] cur;

  // logs
  logic [8:0] lg [64];
  int lg_p [64];
  int lg_n, to_cnt, to_cyc, acc0_cyc, stall_seen;
  int rmode = 0, stall_cnt = 0;
  bit stall_done = 0;

  function automatic int pick(logic [N-1:0] v, int r);
    for (int k = 1; k <= N; k++)
      if (v[(r + k) % N]) return (r + k) % N;
    return -1;
  endfunction

  task automatic push(int p, logic [6:0] pa, logic [7:0] pc, logic pl);
    mem[p][tl[p] % 256] = '{a: pa, c: pc, l: pl};
    tl[p]++;
  endtask

  task automatic drive();
    beat_t b;
    for (int i = 0; i < N; i++) begin
      if (gap[i] > 0) begin
        gap[i]--;
        req_valid[i] = 1'b0;
      end else if (hd[i] != tl[i]) begin
        b = mem[i][hd[i] % 256];
        req_valid[i] = 1'b1;
        req_addr[7*i +: 7] = b.a;
        req_char[8*i +: 8] = b.c;
        req_last[i] = b.l;
      end else begin
        req_valid[i] = 1'b0;
      end
    end
    case (rmode)
      0: lcd_ready = 1'b1;
      1: lcd_ready = ($urandom_range(3) != 0);
      2: begin
        if (stall_cnt > 0) begin
          stall_cnt--;
          lcd_ready = 1'b0;
        end else if (!stall_done && lcd_valid && lcd_rs) begin
          stall_done = 1;
          stall_cnt = 9;
          lcd_ready = 1'b0;
        end else lcd_ready = 1'b1;
      end
      default: lcd_ready = 1'b0;
    endcase
  endtask

  task automatic sample();
    logic [N-1:0] eg, er;
    logic ev, eto, ers, need;
    logic [7:0] ed;
    beat_t b;
    cyc++;
    eg = (owner >= 0) ? N'(1 << owner) : '0;
    ev = (owner >= 0) && !in_lock;
    eto = in_lock && (lock_cnt + 1 == TO);
    ers = 1'b0;
    ed = '0;
    er = '0;
    b = '0;
    if (ev) begin
      b = mem[owner][hd[owner] % 256];
`ifdef LCD_SCHED_ADDR_SKIP_EN
      need = !(cok && b.a == cur);
`else
      need = 1'b1;
`endif
      if (!phase && need) ed = {1'b1, b.a};
      else begin
        ers = 1'b1;
        ed = b.c;
      end
      if (ers && lcd_ready) er = eg;
    end
    chk("grant", grant, eg);
    chk("lcd_valid", lcd_valid, ev);
    chk("timeout_err", timeout_err, eto);
    chk("req_ready", req_ready, er);
    if (ev) begin
      chk("lcd_rs", lcd_rs, ers);
      chk("lcd_data", lcd_data, ed);
      if (!lcd_ready) stall_seen++;
    end
    if (timeout_err) begin
      to_cnt++;
      to_cyc = cyc;
    end
    if (owner < 0) begin
      if (req_valid != 0) begin
        owner = pick(req_valid, rr);
        rr = owner;
        phase = 0;
      end
    end else if (ev) begin
      if (lcd_ready) begin
        if (lg_n < 64) begin
          lg[lg_n] = {ers, ed};
          lg_p[lg_n] = owner;
        end
        lg_n++;
        if (!ers) begin
          cur = b.a;
          cok = 1;
          phase = 1;
        end else begin
          cur = cur + 7'd1;
          phase = 0;
          hd[owner]++;
          gap[owner] = $urandom_range(gmax);
          if (owner == 0) acc0_cyc = cyc;
          if (b.l) owner = -1;
          else begin
            in_lock = 1;
            lock_cnt = 0;
          end
        end
      end
    end else begin
      lock_cnt++;
      if (eto) begin
        owner = -1;
        cok = 0;
        in_lock = 0;
      end else if (req_valid[owner]) begin
        in_lock = 0;
        phase = 0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run(int budget);
    int n;
    n = 0;
    while (n < budget &&
           !(owner < 0 && hd[0] == tl[0] && hd[1] == tl[1])) begin
      cycle();
      n++;
    end
    chk("run_budget", 32'(n < budget), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    req_char = '0;
    req_addr = '0;
    req_last = '0;
    lcd_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      hd[i] = 0;
      tl[i] = 0;
      gap[i] = 0;
    end
    owner = -1;
    rr = N - 1;
    cok = 0;
    cur = '0;
    in_lock = 0;
    phase = 0;
    lock_cnt = 0;
    stall_cnt = 0;
    stall_done = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_lcd_valid", lcd_valid, 0);
    chk("rst_lcd_data", {lcd_rs, lcd_data}, 0);
    chk("rst_timeout", timeout_err, 0);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected end");
    $fatal(1);
  end

  initial begin
    logic [8:0] ex [$];
    logic [9:0] seq;
    int len;
    logic [6:0] a;
    cyc = 0;
    lg_n = 0;
    to_cnt = 0;
    do_reset();

    // "HR" then a jump to the second line
    push(0, 7'h00, 8'h48, 0);
    push(0, 7'h01, 8'h52, 1);
    rmode = 0;
    gmax = 0;
    lg_n = 0;
    run(200);
    push(0, 7'h40, 8'h58, 1);
    run(200);
`ifdef LCD_SCHED_ADDR_SKIP_EN
    ex = '{9'h080, 9'h148, 9'h152, 9'h0C0, 9'h158};
`else
    ex = '{9'h080, 9'h148, 9'h081, 9'h152, 9'h0C0, 9'h158};
`endif
    chk("hr_count", lg_n, ex.size());
    for (int i = 0; i < ex.size(); i++) chk($sformatf("hr_cmd%0d", i), lg[i], ex[i]);

    // contention: two rounds of simultaneous strings
    do_reset();
    gmax = 2;
    lg_n = 0;
    for (int r = 0; r < 2; r++) begin
      push(0, 7'h10, 8'h61, 0);
      push(0, 7'h11, 8'h62, 0);
      push(0, 7'h12, 8'h63, 1);
      push(1, 7'h50, 8'h71, 0);
      push(1, 7'h51, 8'h72, 1);
      run(300);
    end
    seq = '0;
    len = 0;
    for (int i = 0; i < lg_n && i < 64; i++)
      if (lg[i][8]) begin
        seq = {seq[8:0], lg_p[i][0]};
        len++;
      end
    chk("cont_len", len, 10);
    chk("cont_order", seq, 10'b0001100011);

    // backpressure during CHAR
    rmode = 2;
    gmax = 0;
    stall_done = 0;
    stall_seen = 0;
    push(0, 7'h20, 8'h41, 0);
    push(0, 7'h21, 8'h42, 1);
    run(300);
    chk("stall_cycles", stall_seen, 10);
    rmode = 0;

    // lock timeout with port 1 waiting
    do_reset();
    to_cnt = 0;
    push(0, 7'h30, 8'h54, 0);
    push(1, 7'h31, 8'h55, 1);
    run(300);
    chk("tmo_pulses", to_cnt, 1);
    chk("tmo_delay", to_cyc - acc0_cyc, TO);

    // reset while ADDR is stalled
    do_reset();
    rmode = 3;
    push(0, 7'h00, 8'h5A, 1);
    repeat (4) cycle();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_valid", lcd_valid, 0);
    chk("arst_cmd", {lcd_rs, lcd_data}, 0);
    chk("arst_ready", req_ready, 0);
    do_reset();
    rmode = 0;
    lg_n = 0;
    push(0, 7'h00, 8'h5A, 1);
    push(1, 7'h00, 8'h59, 1);
    run(200);
    chk("arst_first_cmd", lg[0], 9'h080);
    chk("arst_first_port", lg_p[0], 0);

    // random strings on both ports
    rmode = 1;
    gmax = 2;
    for (int p = 0; p < N; p++)
      for (int s = 0; s < 12; s++) begin
        len = $urandom_range(1, 4);
        a = 7'($urandom);
        for (int k = 0; k < len; k++) begin
          push(p, a, 8'($urandom_range(32, 126)), k == len - 1);
          a = ($urandom_range(3) == 0) ? 7'($urandom) : a + 7'd1;
        end
      end
    run(5000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/lcd_write_sched.md
# lcd_write_sched

Scheduler that shares the single HD44780-style LCD command engine between several character requesters, e.g. the heart-rate digit formatter and the status/alarm text source. It grants one requester at a time with round-robin arbitration and holds the grant for a whole string, up to the `last` beat. It converts each (address, character) beat into a set-DDRAM-address command plus a data write, and presents them on a valid/ready command port. The block sits between the display-content sources and the LCD timing engine that drives `e/rs/rw/data`.

## Interface
- `N_REQ`, default 2: number of requesters, range 2..4.
- `TIMEOUT_CYC`, default 5_000_000: idle cycles allowed inside a locked string before the grant is revoked (100 ms at 50 MHz).
- `clk  in  1`: system clock.
- `reset  in  1`: asynchronous, active-high reset.
- `req_valid  in  N_REQ`: requester i has a character beat.
- `req_ready  out  N_REQ`: beat i consumed this cycle.
- `req_char  in  8*N_REQ`: ASCII code, slice i.
- `req_addr  in  7*N_REQ`: DDRAM address, slice i.
- `req_last  in  N_REQ`: beat is the final character of the string.
- `lcd_valid  out  1`: command presented to the engine.
- `lcd_ready  in  1`: engine accepts the command this cycle.
- `lcd_rs  out  1`: 0 = instruction, 1 = data.
- `lcd_data  out  8`: instruction or character byte.
- `grant  out  N_REQ`: one-hot owner, or 0 when idle.
- `timeout_err  out  1`: single-cycle pulse when a grant is revoked.

## Operation
- States: IDLE, LOCK, ADDR, CHAR.
- IDLE
  - If any `req_valid` is high, pick the first valid port after `rr_ptr` (wrapping).
  - Set `grant`, update `rr_ptr` to the winner, and go to ADDR, or to CHAR if the skip condition holds (see Configuration).
- ADDR
  - Outputs: `lcd_valid=1`, `lcd_rs=0`, `lcd_data={1'b1, req_addr[i]}`.
  - On `lcd_valid && lcd_ready`: set `cursor = req_addr[i]`, set `cursor_ok = 1`, go to CHAR.
- CHAR
  - Outputs: `lcd_valid=1`, `lcd_rs=1`, `lcd_data=req_char[i]`.
  - `req_ready[i] = grant[i] && state==CHAR && lcd_ready` (combinational).
  - On accept, `cursor` is incremented modulo 128 (0x7F wraps to 0x00).
  - If `req_last[i]`, go to IDLE and clear `grant`; otherwise go to LOCK.
- LOCK
  - The grant is held and the idle timer counts.
  - If `req_valid[i]`, clear the timer and go to ADDR or CHAR.
  - Other requesters are ignored, even if valid.
  - When the timer reaches `TIMEOUT_CYC-1`: pulse `timeout_err`, clear `grant` and `cursor_ok`, go to IDLE.
- Requester rules
  - Must hold `req_char`, `req_addr` and `req_last` stable while `req_valid` is high and `req_ready` is low.
  - Dropping `req_valid` before `ready` is illegal; behaviour is undefined.
- Engine rules
  - `lcd_rs` and `lcd_data` are stable while `lcd_valid && !lcd_ready`.
  - `lcd_valid` never drops without an accept.
- Reset (asynchronous, any state)
  - State goes to IDLE.
  - `grant=0`, `lcd_valid=0`, `lcd_rs=0`, `lcd_data=0`, `timeout_err=0`, `cursor=0`, `cursor_ok=0`, timer 0.
  - `rr_ptr = N_REQ-1`, so port 0 wins the first arbitration.
  - A command pending at reset is dropped and is not replayed.

## Timing
- Arbitration: `req_valid` is sampled in IDLE at cycle N; `grant` and `lcd_valid` are registered high at N+1.
- ADDR accepted at cycle M → CHAR `lcd_valid` at M+1. Back-to-back accepts cost 1 cycle per command.
- CHAR accepted at M → `req_ready` at M (same cycle).
  - Next beat: ADDR/CHAR valid at M+2 (via LOCK).
  - If `last`: IDLE at M+1, next grant at M+2.
- Simultaneous requests in IDLE are resolved by round-robin only. A port that was just served has the lowest priority.
- Timeout revocation lands on the `TIMEOUT_CYC`th consecutive LOCK cycle without `req_valid[i]`.
- If `req_valid[i]` arrives in that same cycle, the timeout still wins.

## Configuration
- `LCD_SCHED_ADDR_SKIP_EN` defined:
  - The ADDR state is skipped when `cursor_ok && req_addr[i]==cursor`.
  - Contiguous strings cost one command per character.
- `LCD_SCHED_ADDR_SKIP_EN` undefined:
  - Every beat emits ADDR then CHAR.
  - `cursor` and `cursor_ok` are not used for decisions.

## Test plan
- Single string, macro undefined: port 0 sends "HR" at addr 0x00/0x01 with `last` on 'R', `lcd_ready=1`.
  - Required engine sequence: (rs0,0x80),(rs1,0x48),(rs0,0x81),(rs1,0x52).
  - `grant` returns to 0 the cycle after the 'R' accept.
- Address skip, macro defined: the same stimulus yields (rs0,0x80),(rs1,0x48),(rs1,0x52).
  - A following beat at addr 0x40 emits 0xC0 first.
- Contention: ports 0 and 1 are both valid in IDLE after reset.
  - Port 0 is served fully (3 chars, `last`), then port 1.
  - A second simultaneous request is then served port 0 first.
  - Port 1's beats never interleave within port 0's string.
- Backpressure: hold `lcd_ready=0` for 10 cycles during CHAR.
  - `lcd_data` stays stable and `req_ready` stays 0 until `lcd_ready` rises.
- Timeout: with `TIMEOUT_CYC=16`, port 0 sends one non-last beat then idles.
  - `timeout_err` pulses exactly 16 LOCK cycles later and `grant` clears.
  - Port 1, valid throughout, is granted on the next cycle.
- Reset mid-command: assert `reset` while ADDR is stalled.
  - All outputs go to 0 asynchronously.
  - After release, port 0 is granted first and the first command is ADDR even with the macro defined.
